// File: rtl/mulu_int_if.sv
// Start/busy/done/valid handshake bundle for the shift-and-add multiply-accumulate unit.
// The master drives the operands and start. The slave returns the status and the result.
interface mulu_int_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               busy;
  logic               done;
  logic               valid;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [2*WIDTH-1:0] val;

  modport master (output start, a, b, c, input busy, done, valid, val);
  modport slave  (input start, a, b, c, output busy, done, valid, val);
endinterface

// File: rtl/mulu_int.sv
// Sequential unsigned val = a*b + c, consuming one multiplier bit per clock.
// Optional macro MULU_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module mulu_int #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mulu_int_if.slave     bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RES_W = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RES_W-1:0]   acc_reg, acc_next;
  logic [RES_W-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [RES_W-1:0]   val_reg, val_next;
  logic               done_reg, done_next;
  logic               valid_reg, valid_next;
  logic [RES_W-1:0]   sum;
  logic               last;

  // The adder is the full result width; the sum is the accumulator after this iteration.
  assign sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

`ifdef MULU_EARLY_EXIT_EN
  assign last = (cnt_reg == CNT_W'(WIDTH - 1)) || (mplier_reg[WIDTH-1:1] == '0);
`else
  assign last = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      val_reg    <= '0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      val_reg    <= val_next;
      done_reg   <= done_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    val_next    = val_reg;
    done_next   = 1'b0;
    valid_next  = valid_reg;

    // A start always (re)loads the operands, abandoning any calculation in flight.
    if (bus.start) begin
      state_next  = RUN;
      cnt_next    = '0;
      acc_next    = {{WIDTH{1'b0}}, bus.c};
      mcand_next  = {{WIDTH{1'b0}}, bus.a};
      mplier_next = bus.b;
      valid_next  = 1'b0;
    end else if (state_reg == RUN) begin
      acc_next    = sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg + 1'b1;
      if (last) begin
        state_next = IDLE;
        val_next   = sum;
        done_next  = 1'b1;
        valid_next = 1'b1;
      end
    end
  end

  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = done_reg;
  assign bus.valid = valid_reg;
  assign bus.val   = val_reg;
endmodule

// File: tb/tb_mulu_int.sv
// Directed vector table plus handshake corner sequences for mulu_int (WIDTH=8).
module tb_mulu_int;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mulu_int_if #(.WIDTH(W)) bus ();
  mulu_int #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp_val;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycles from start to done for a given multiplier.
  function automatic int lat_of(input logic [W-1:0] b);
`ifdef MULU_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i;
    return hi + 2;
`else
    return (b == 0) ? W + 1 : W + 1;
`endif
  endfunction

  // Pulses start in the current cycle. It returns in the done cycle, or when the cycle budget runs out.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       output int lat);
    bus.start = 1'b1;
    bus.a = a; bus.b = b; bus.c = c;
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
    check("busy_after_start", 32'(bus.busy), 1);
    check("valid_low_after_start", 32'(bus.valid), 0);
    lat = 1;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] ra, rb, rc;

    vecs[0]  = '{8'd13,  8'd11,  8'd7,   16'd150};
    vecs[1]  = '{8'd255, 8'd255, 8'd255, 16'd65280};
    vecs[2]  = '{8'd0,   8'd0,   8'd0,   16'd0};
    vecs[3]  = '{8'd1,   8'd1,   8'd0,   16'd1};
    vecs[4]  = '{8'd0,   8'd200, 8'd17,  16'd17};
    vecs[5]  = '{8'd128, 8'd2,   8'd0,   16'd256};
    vecs[6]  = '{8'd100, 8'd0,   8'd5,   16'd5};
    vecs[7]  = '{8'd15,  8'd17,  8'd3,   16'd258};
    vecs[8]  = '{8'd255, 8'd1,   8'd0,   16'd255};
    vecs[9]  = '{8'd1,   8'd255, 8'd255, 16'd510};
    vecs[10] = '{8'd10,  8'd3,   8'd0,   16'd30};
    vecs[11] = '{8'd5,   8'd0,   8'd9,   16'd9};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_val", 32'(bus.val), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, lat);
      $display("[TB] vec %0d: a=%0d b=%0d c=%0d val=%0d lat=%0d", i, vecs[i].a, vecs[i].b, vecs[i].c, bus.val, lat);
      check("vec_latency", 32'(lat), 32'(lat_of(vecs[i].b)));
      check("vec_val", 32'(bus.val), 32'(vecs[i].exp_val));
      check("vec_valid", 32'(bus.valid), 1);
      check("vec_busy_in_done", 32'(bus.busy), 0);
      tick();
      check("vec_done_one_cycle", 32'(bus.done), 0);
      check("vec_valid_holds", 32'(bus.valid), 1);
    end

    // Restart at T+4: the first calculation must produce no done pulse.
    bus.start = 1'b1; bus.a = 8'd20; bus.b = 8'd6; bus.c = 8'd0;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      pulses += int'(bus.done);
      tick();
    end
    pulses += int'(bus.done);
    do_op(8'd3, 8'd4, 8'd1, lat);
    $display("[TB] restart: val=%0d lat=%0d", bus.val, lat);
    check("restart_no_early_done", 32'(pulses), 0);
    check("restart_latency", 32'(lat + 4), 32'(4 + lat_of(8'd4)));
    check("restart_val", 32'(bus.val), 13);

    // A start in the done cycle begins a new calculation at once.
    do_op(8'd2, 8'd3, 8'd4, lat);
    $display("[TB] back-to-back: val=%0d lat=%0d", bus.val, lat);
    check("b2b_latency", 32'(lat), 32'(lat_of(8'd3)));
    check("b2b_val", 32'(bus.val), 10);
    tick();

    // Reset at T+5 during a calculation.
    bus.start = 1'b1; bus.a = 8'd77; bus.b = 8'd200; bus.c = 8'd1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_busy", 32'(bus.busy), 0);
    check("midreset_done", 32'(bus.done), 0);
    check("midreset_valid", 32'(bus.valid), 0);
    check("midreset_val", 32'(bus.val), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulses += int'(bus.done);
    end
    $display("[TB] mid-run reset: done pulses after reset=%0d", pulses);
    check("midreset_no_done", 32'(pulses), 0);

    // Random sweep against a*b+c.
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      do_op(ra, rb, rc, lat);
      $display("[TB] rand %0d: a=%0d b=%0d c=%0d val=%0d lat=%0d", k, ra, rb, rc, bus.val, lat);
      check("rand_val", 32'(bus.val), 32'(ra) * 32'(rb) + 32'(rc));
      check("rand_latency", 32'(lat), 32'(lat_of(rb)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mulu_int.md
Name: mulu_int

Overview:
- Sequential unsigned integer multiply-accumulate: computes val = a*b + c by shift-and-add, one multiplier bit per clock.
- Inverse companion to the unsigned divider: feeding it quotient, divisor and remainder reconstructs the dividend.
- Same start/busy/done/valid handshake as the other lib/maths blocks, so the two can be chained or swapped in a maths pipeline.

Parameters:
- WIDTH, 8, width of operands a, b, c in bits (minimum 2); result is 2*WIDTH bits.

Ports:
- clk    input   1          clock
- rst_n  input   1          synchronous reset, active-low
- start  input   1          start calculation; operands sampled on this edge
- busy   output  1          calculation in progress
- done   output  1          calculation complete; high for exactly one cycle
- valid  output  1          val holds a result from the most recent start
- a      input   WIDTH      multiplicand
- b      input   WIDTH      multiplier
- c      input   WIDTH      addend (zero-extended)
- val    output  2*WIDTH    result a*b + c

Behaviour:
- Reset (rst_n low at a clk edge):
  - busy=0, done=0, valid=0, val=0; internal counter cleared.
  - Reset wins over start and over an in-flight calculation.
  - Any in-flight result is discarded, with no done pulse.
- Internal state:
  - acc: 2*WIDTH bits, initialised to c zero-extended.
  - mcand: 2*WIDTH bits, initialised to a zero-extended.
  - mplier: WIDTH bits, initialised to b.
  - Iteration counter: $clog2(WIDTH+1) bits.
- States: IDLE (busy=0) and RUN (busy=1). A separate one-cycle done pulse is raised on leaving RUN.
- IDLE, start=1:
  - Load operands, counter=0, busy<=1, valid<=0.
  - val holds its previous value but is not valid.
- RUN, each clock:
  - If mplier[0]=1: acc <= acc + mcand.
  - Then mcand <= mcand << 1, mplier <= mplier >> 1, counter++.
- Iteration WIDTH-1 (the final one):
  - val <= final acc, including that iteration's add.
  - busy<=0, done<=1, valid<=1.
- Latency: start high in cycle T gives busy high in cycles T+1..T+WIDTH, and done and valid high in cycle T+WIDTH+1.
  - This holds for all operand values, including zeros (no special-casing).
- done deasserts on the next clock. valid stays high until the next start or reset.
- Width rule: no overflow is possible, since max = (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W. The adder must nevertheless be a full 2*WIDTH bits, with no truncation.
- start while busy: restart, abandoning the current calculation.
  - No done pulse for the abandoned calculation.
  - Operands are reloaded and latency is counted afresh from the new start.
- start in the same cycle done is high: legal. done falls, valid falls, and a new calculation begins.
- Inputs a, b, c may change freely while busy; only the values at the start edge matter.

Optional Feature:
- Macro MULU_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the remaining mplier is zero, finish this cycle: val <= acc, done<=1, valid<=1, busy<=0.
  - Latency becomes (index of the highest set bit of b) + 2 cycles from start to done.
  - b=0 gives done at T+2 with val=c.
  - Results are identical to the fixed-latency mode.
- Undefined: fixed latency of WIDTH+1 cycles, with no zero-detect logic.

Test Plan (WIDTH=8 unless noted):
- a=13, b=11, c=7, start high in cycle T -> busy high T+1..T+8; done one cycle at T+9; val=150, valid=1.
- a=255, b=255, c=255 -> val=65280 (0xFF00), no truncation. Then a=0, b=0, c=0 -> val=0 with full 9-cycle latency (macro undefined).
- Start a=20, b=6, c=0; re-pulse start at T+4 with a=3, b=4, c=1 -> no done for the first operation; done at T+13 with val=13.
- rst_n low at T+5 mid-calculation -> busy=0, done=0, valid=0, val=0 next cycle; no done pulse afterwards.
- Back-to-back: start asserted in the done cycle with a=2, b=3, c=4 -> done falls, new done 9 cycles later with val=10.
- MULU_EARLY_EXIT_EN defined:
  - a=10, b=3, c=0 -> done at T+3, val=30.
  - b=0, c=9 -> done at T+2, val=9.
  - Random sweep matches the reference model a*b+c.
